pc_branch_unit: RTL and testbench

- Program-counter sequencer that consumes the 16-bit branch Target produced by the branch target lookup table.
- Holds ProgCtr, steps it each cycle, and applies taken branches as either relative (signed add) or absolute (load).
- Runs a small run/halt state machine: Start launches the program, Halt ends it and raises Done.
- Sits between the decode/lookup logic and the instruction ROM address input.

---
 rtl/pc_branch_unit.sv | 116 +++++++++++
 tb/tb_pc_branch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Program counter sequencer with run/halt control; branches land on ProgCtr one cycle after they are presented.
// Stall holds ProgCtr and drops a coincident branch. Optional accepted-branch counter under PC_BRANCH_COUNT_EN.
module pc_branch_unit #(
  parameter int unsigned     PC_W       = 16,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            BranchEn,
  input  logic            BranchAbs,
  input  logic [15:0]     Target,
  input  logic            Halt,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Fetch,
  output logic            Flush,
`ifdef PC_BRANCH_COUNT_EN
  output logic [15:0]     BranchCount,
`endif
  output logic            Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic [PC_W-1:0] tgt_rel;
  logic [PC_W-1:0] tgt_abs;

  // Relative offsets are signed, absolute targets are plain addresses.
  generate
    if (PC_W <= 16) begin : g_tgt_narrow
      assign tgt_rel = Target[PC_W-1:0];
      assign tgt_abs = Target[PC_W-1:0];
    end else begin : g_tgt_wide
      assign tgt_rel = {{(PC_W-16){Target[15]}}, Target};
      assign tgt_abs = {{(PC_W-16){1'b0}}, Target};
    end
  endgenerate

`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
`ifdef PC_BRANCH_COUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
`ifdef PC_BRANCH_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      RUN: begin
        if (Halt) begin
          state_d = DONE;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (BranchEn) begin
          pc_d    = BranchAbs ? tgt_abs : (pc_q + tgt_rel);
          flush_d = 1'b1;
`ifdef PC_BRANCH_COUNT_EN
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_ADDR;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      flush_q <= 1'b0;
`ifdef PC_BRANCH_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
`ifdef PC_BRANCH_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ProgCtr = pc_q;
  assign Flush   = flush_q;
  assign Fetch   = (state_q == RUN);
  assign Done    = (state_q == DONE);
`ifdef PC_BRANCH_COUNT_EN
  assign BranchCount = cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a reference model queues expected outputs per cycle, compared after each edge.
module tb_pc_branch_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Stall;
  logic        BranchEn;
  logic        BranchAbs;
  logic [15:0] Target;
  logic        Halt;
  logic [15:0] ProgCtr;
  logic        Fetch;
  logic        Flush;
  logic        Done;
`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] BranchCount;
`endif

  pc_branch_unit #(.PC_W(16), .START_ADDR(16'h0000)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Stall     (Stall),
    .BranchEn  (BranchEn),
    .BranchAbs (BranchAbs),
    .Target    (Target),
    .Halt      (Halt),
    .ProgCtr   (ProgCtr),
    .Fetch     (Fetch),
    .Flush     (Flush),
`ifdef PC_BRANCH_COUNT_EN
    .BranchCount(BranchCount),
`endif
    .Done      (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [15:0] pc;
    logic        fetch;
    logic        flush;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: 0 idle, 1 run, 2 done.
  int          m_state = 0;
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_cnt   = 16'h0000;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 16'h0000;
    m_cnt   = 16'h0000;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare them after the edge.
  task automatic step(input logic st, input logic sl, input logic be, input logic ba,
                      input logic [15:0] tg, input logic hl);
    exp_t e;
    exp_t o;
    Start = st; Stall = sl; BranchEn = be; BranchAbs = ba; Target = tg; Halt = hl;
    e.flush = 1'b0;
    if (m_state == 1) begin
      if (hl) begin
        m_state = 2;
      end else if (!sl) begin
        if (be) begin
          m_pc    = ba ? tg : 16'(m_pc + tg);
          e.flush = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          m_pc = m_pc + 16'd1;
        end
      end
    end else if (st) begin
      m_state = 1;
      m_pc    = 16'h0000;
      m_cnt   = 16'h0000;
    end
    e.pc    = m_pc;
    e.fetch = (m_state == 1);
    e.done  = (m_state == 2);
    e.cnt   = m_cnt;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
    end else begin
      o = sb.pop_front();
      check("pc",    ProgCtr,      o.pc);
      check("fetch", 16'(Fetch),   16'(o.fetch));
      check("flush", 16'(Flush),   16'(o.flush));
      check("done",  16'(Done),    16'(o.done));
`ifdef PC_BRANCH_COUNT_EN
      check("count", BranchCount,  o.cnt);
`endif
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic br(input logic ba, input logic [15:0] tg);
    step(1'b0, 1'b0, 1'b1, ba, tg, 1'b0);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
    BranchAbs = 1'b0; Target = 16'h0000; Halt = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_pc",    ProgCtr,     16'h0000);
    check("rst_fetch", 16'(Fetch),  16'd0);
    check("rst_flush", 16'(Flush),  16'd0);
    check("rst_done",  16'(Done),   16'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // Start, then free-run 0..5
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("first_pc", ProgCtr, 16'h0000);
    repeat (5) idle();
    check("seq_pc5", ProgCtr, 16'h0005);

    // Relative -1 from 5, then resume
    br(1'b0, 16'hFFFF);
    check("rel_neg_pc", ProgCtr, 16'h0004);
    check("rel_neg_flush", 16'(Flush), 16'd1);
    idle();
    check("after_rel_pc", ProgCtr, 16'h0005);

    // Back-to-back branches: abs to 0x10, rel +3, abs 0x0F03
    br(1'b1, 16'h0010);
    br(1'b0, 16'h0003);
    check("rel_pos_pc", ProgCtr, 16'h0013);
    br(1'b1, 16'h0F03);
    check("abs_pc", ProgCtr, 16'h0F03);
    check("abs_flush", 16'(Flush), 16'd1);
    idle();

    // Relative zero loops on the same address
    br(1'b0, 16'h0000);
    check("rel_zero_pc", ProgCtr, 16'h0F04);

    // Wrap and stall-with-branch
    br(1'b1, 16'hFFFF);
    idle();
    check("wrap_pc", ProgCtr, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
    check("stall_pc", ProgCtr, 16'h0000);
    check("stall_flush", 16'(Flush), 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Halt beats branch at 7; DONE ignores everything but Start
    br(1'b1, 16'h0007);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b1);
    check("halt_pc", ProgCtr, 16'h0007);
    check("halt_done", 16'(Done), 16'd1);
    check("halt_fetch", 16'(Fetch), 16'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0009, 1'b1);
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("restart_pc", ProgCtr, 16'h0000);
    check("restart_done", 16'(Done), 16'd0);

    // Asynchronous reset mid-run at 0x42
    br(1'b1, 16'h0042);
    idle();
    Reset = 1'b0;
    #1;
    model_reset();
    check("arst_pc", ProgCtr, 16'h0000);
    check("arst_fetch", 16'(Fetch), 16'd0);
    check("arst_flush", 16'(Flush), 16'd0);
    @(negedge Clk);
    Reset = 1'b1;
    br(1'b1, 16'h0055);
    idle();
    check("idle_hold_pc", ProgCtr, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Random mix
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           1'($urandom_range(0, 1)),
           16'($urandom),
           $urandom_range(0, 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
